// File: rtl/ahb_arbiter.sv
// AHB bus arbiter for NUM_MST masters sharing one slave path.
// Tracks fixed-length bursts, honours locked sequences, masks masters that
// were SPLIT until the slave releases them through HSPLIT.
// Optional macro AHB_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest-numbered eligible master wins.
module ahb_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic [1:0]         HRESP,
    input  logic [15:0]        HSPLIT,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [3:0]         HMASTER,
    output logic               HMASTLOCK
);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [1:0] RSP_OKAY  = 2'd0;
    localparam logic [1:0] RSP_SPLIT = 2'd3;
    localparam logic [2:0] BU_INCR   = 3'd1;
    localparam logic [NUM_MST-1:0] ONE_HOT1  = NUM_MST'(1);
    localparam logic [NUM_MST-1:0] DEF_GRANT = ONE_HOT1 << DEF_MST;

    logic [NUM_MST-1:0] grant, grant_nxt, mask, mask_nxt, eligible;
    logic [3:0]         grant_idx, data_owner, cnt, cnt_nxt, len_m1, win;
    logic               err, split_rsp, owner_locked, owner_keep, ap, found;
    logic               unused_hsplit;

    // Upper HSPLIT bits beyond NUM_MST have no master to release
    assign unused_hsplit = ^HSPLIT;
    assign HGRANT        = grant;

    assign err          = HREADY && (HRESP != RSP_OKAY);
    assign split_rsp    = HREADY && (HRESP == RSP_SPLIT);
    assign owner_locked = |(HBUSREQ & HLOCK & grant);
    // An unfinished fixed burst stays with its owner while it still wants the bus
    assign owner_keep   = (|(HBUSREQ & ~mask_nxt & grant)) && (cnt_nxt != 4'd0);
    // A locked owner can only be pre-empted by a SPLIT
    assign ap = split_rsp ||
                (HREADY && !owner_locked &&
                 (HTRANS == TR_IDLE || cnt_nxt == 4'd0 || HBURST == BU_INCR || err));
    assign eligible = HBUSREQ & ~mask_nxt;

    // Index of the master currently holding the grant
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MST; i++)
            if (grant[i]) grant_idx = 4'(i);
    end

    // Beats remaining after the first beat of a burst
    always_comb begin
        case (HBURST)
            3'd2, 3'd3: len_m1 = 4'd3;
            3'd4, 3'd5: len_m1 = 4'd7;
            3'd6, 3'd7: len_m1 = 4'd15;
            default:    len_m1 = 4'd0;
        endcase
    end

    // Beat counter: load on NONSEQ, count SEQ beats, cleared by any error response
    always_comb begin
        cnt_nxt = cnt;
        if (HREADY) begin
            if (HTRANS == TR_NONSEQ)
                cnt_nxt = len_m1;
            else if (HTRANS == TR_SEQ && cnt != 4'd0)
                cnt_nxt = cnt - 4'd1;
            if (err)
                cnt_nxt = 4'd0;
        end
    end

    // Split mask: release first, then a fresh SPLIT so set wins on the same bit
    always_comb begin
        mask_nxt = mask & ~HSPLIT[NUM_MST-1:0];
        if (split_rsp)
            for (int i = 0; i < NUM_MST; i++)
                if (data_owner == 4'(i)) mask_nxt[i] = 1'b1;
    end

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [3:0] rr_ptr;
    logic [4:0] dist, best_dist;

    // Eligible master closest to the pointer (circular distance) wins
    always_comb begin
        win       = 4'(DEF_MST);
        found     = 1'b0;
        best_dist = '1;
        dist      = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (eligible[i]) begin
                dist = (5'(i) >= {1'b0, rr_ptr}) ? 5'(i) - {1'b0, rr_ptr}
                                                 : 5'(i) + 5'(NUM_MST) - {1'b0, rr_ptr};
                if (dist < best_dist) begin
                    best_dist = dist;
                    win       = 4'(i);
                    found     = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past each master that wins a fresh arbitration
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            rr_ptr <= '0;
        else if (ap && !owner_keep && found)
            rr_ptr <= (win == 4'(NUM_MST - 1)) ? 4'd0 : win + 4'd1;
    end
`else
    // Fixed priority: scanning downward leaves the lowest eligible index
    always_comb begin
        win   = 4'(DEF_MST);
        found = 1'b0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win   = 4'(i);
                found = 1'b1;
            end
        end
    end
`endif

    // Next grant: only moves at an arbitration point; idle bus parks on DEF_MST
    always_comb begin
        grant_nxt = grant;
        if (ap && !owner_keep)
            grant_nxt = found ? (ONE_HOT1 << win) : DEF_GRANT;
    end

    // Grant, burst, mask and address/data-phase ownership registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant      <= DEF_GRANT;
            cnt        <= '0;
            mask       <= '0;
            HMASTER    <= 4'(DEF_MST);
            HMASTLOCK  <= 1'b0;
            data_owner <= 4'(DEF_MST);
        end else begin
            grant <= grant_nxt;
            cnt   <= cnt_nxt;
            mask  <= mask_nxt;
            if (HREADY) begin
                HMASTER    <= grant_idx;
                HMASTLOCK  <= |(HLOCK & grant & ~mask);
                data_owner <= HMASTER;
            end
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_ahb_arbiter;
    localparam int N   = 4;
    localparam int DEF = 0;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5;
    localparam logic [1:0] OKAY = 2'd0, RETRY = 2'd2, SPLIT = 2'd3;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [N-1:0] HBUSREQ, HLOCK, HGRANT;
    logic [1:0]   HTRANS, HRESP;
    logic [2:0]   HBURST;
    logic         HREADY, HMASTLOCK;
    logic [15:0]  HSPLIT;
    logic [3:0]   HMASTER;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int       m_g, m_master, m_dow, m_cnt, m_ptr;
    bit       m_lock;
    bit [15:0] m_mask;
    logic [N-1:0] got [5];

    ahb_arbiter #(.NUM_MST(N), .DEF_MST(DEF)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
        .HSPLIT(HSPLIT), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_g = DEF; m_master = DEF; m_dow = DEF; m_cnt = 0; m_ptr = 0;
        m_lock = 1'b0; m_mask = '0;
    endtask

    // One clock edge of the arbitration rules
    task automatic model_edge();
        int cn, g_new, best, start, j;
        bit [15:0] mk;
        bit err, lkd, ap, keep;
        err = HREADY && HRESP != OKAY;
        cn  = m_cnt;
        if (HREADY) begin
            if (HTRANS == NSEQ) cn = blen(HBURST) - 1;
            else if (HTRANS == SEQ && m_cnt > 0) cn = m_cnt - 1;
            if (err) cn = 0;
        end
        mk = m_mask;
        for (int i = 0; i < N; i++) if (HSPLIT[i]) mk[i] = 1'b0;
        if (HREADY && HRESP == SPLIT) mk[m_dow] = 1'b1;
        lkd  = HLOCK[m_g] && HBUSREQ[m_g];
        ap   = (HREADY && HRESP == SPLIT) ||
               (HREADY && !lkd && (HTRANS == IDLE || cn == 0 || HBURST == 3'd1 || err));
        keep = HBUSREQ[m_g] && !mk[m_g] && cn != 0;
        g_new = m_g;
        if (ap && !keep) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
            start = m_ptr;
`else
            start = 0;
`endif
            best = -1;
            for (int k = 0; k < N; k++) begin
                j = (start + k) % N;
                if (best < 0 && HBUSREQ[j] && !mk[j]) best = j;
            end
            if (best >= 0) begin
                g_new = best;
                m_ptr = (best + 1) % N;
            end else
                g_new = DEF;
        end
        if (HREADY) begin
            m_dow    = m_master;
            m_master = m_g;
            m_lock   = HLOCK[m_g] && !m_mask[m_g];
        end
        m_g = g_new; m_cnt = cn; m_mask = mk;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = N'(1) << m_g;
        chk({tag, "_grant"}, 32'(HGRANT), 32'(eg));
        chk({tag, "_master"}, 32'(HMASTER), 32'(m_master));
        chk({tag, "_lock"}, 32'(HMASTLOCK), 32'(m_lock));
        chk({tag, "_onehot"}, 32'($countones(HGRANT)), 32'd1);
    endtask

    // Called at posedge+1: apply inputs, advance one edge, compare at posedge+1
    task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [1:0] rs,
                       input logic [15:0] sp);
        HBUSREQ = rq; HLOCK = lk; HTRANS = tr; HBURST = bu;
        HREADY = rdy; HRESP = rs; HSPLIT = sp;
        @(posedge HCLK);
        model_edge();
        #1;
        check_model("cyc");
    endtask

    // Asynchronous reset asserted between edges, held across one edge
    task automatic do_reset();
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_model("rst_async");
        chk("rst_grant", 32'(HGRANT), 32'h1);
        HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE;
        HREADY = 1'b1; HRESP = OKAY; HSPLIT = '0;
        @(posedge HCLK);
        #1;
        check_model("rst_hold");
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE;
        HREADY = 1'b1; HRESP = OKAY; HSPLIT = '0;
        model_reset();
        #6;

        // 1: idle bus parks on the default master
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc('0, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
            chk("t1_grant", 32'(HGRANT), 32'h1);
            chk("t1_master", 32'(HMASTER), 32'h0);
            chk("t1_lock", 32'(HMASTLOCK), 32'h0);
        end

        // 5: all masters issuing SINGLEs
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, '0, NSEQ, SINGLE, 1'b1, OKAY, '0);
            got[i] = HGRANT;
        end
`ifdef AHB_ARB_ROUND_ROBIN_EN
        chk("t5_g0", 32'(got[0]), 32'h1); chk("t5_g1", 32'(got[1]), 32'h2);
        chk("t5_g2", 32'(got[2]), 32'h4); chk("t5_g3", 32'(got[3]), 32'h8);
        chk("t5_g4", 32'(got[4]), 32'h1);
`else
        for (int i = 0; i < 5; i++) chk("t5_fixed", 32'(got[i]), 32'h1);
`endif

        // 2: INCR4 with a BUSY beat holds the grant until the last SEQ
        do_reset();
        cyc(4'b0010, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        chk("t2_granted", 32'(HGRANT), 32'h2);
        cyc(4'b0010, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0110, '0, NSEQ, INCR4, 1'b1, OKAY, '0);
        chk("t2_nseq", 32'(HGRANT), 32'h2);
        cyc(4'b0110, '0, BUSY, INCR4, 1'b1, OKAY, '0);
        chk("t2_busy", 32'(HGRANT), 32'h2);
        cyc(4'b0110, '0, SEQ, INCR4, 1'b1, OKAY, '0);
        chk("t2_seq1", 32'(HGRANT), 32'h2);
        cyc(4'b0100, '0, SEQ, INCR4, 1'b1, OKAY, '0);
        chk("t2_seq2", 32'(HGRANT), 32'h2);
        cyc(4'b0100, '0, SEQ, INCR4, 1'b1, OKAY, '0);
        chk("t2_handover", 32'(HGRANT), 32'h4);

        // 3: locked SINGLEs from M1 keep M2 out
        do_reset();
        cyc(4'b0010, 4'b0010, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0110, 4'b0010, IDLE, SINGLE, 1'b1, OKAY, '0);
        chk("t3_mlock", 32'(HMASTLOCK), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0110, 4'b0010, NSEQ, SINGLE, 1'b1, OKAY, '0);
            chk("t3_grant", 32'(HGRANT), 32'h2);
            chk("t3_master", 32'(HMASTER), 32'h1);
            chk("t3_lock", 32'(HMASTLOCK), 32'h1);
        end
        cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, '0);
        chk("t3_release", 32'(HGRANT), 32'h4);

        // 4: SPLIT masks M2, HSPLIT releases it, RETRY does not mask
        do_reset();
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0100, '0, NSEQ, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0110, '0, IDLE, SINGLE, 1'b0, SPLIT, '0);
        cyc(4'b0110, '0, IDLE, SINGLE, 1'b1, SPLIT, '0);
        chk("t4_split_m1", 32'(HGRANT), 32'h2);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        chk("t4_masked_def", 32'(HGRANT), 32'h1);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, 16'h0004);
        chk("t4_unmask", 32'(HGRANT), 32'h4);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b0, RETRY, '0);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, RETRY, '0);
        chk("t4_retry", 32'(HGRANT), 32'h4);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        chk("t4_retry_nomask", 32'(HGRANT), 32'h4);

        // 6: split M2 again, then reset in the middle of an INCR8 by M3
        cyc(4'b1100, '0, IDLE, SINGLE, 1'b1, SPLIT, '0);
        chk("t6_m3", 32'(HGRANT), 32'h8);
        cyc(4'b1000, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        cyc(4'b1000, '0, NSEQ, INCR8, 1'b1, OKAY, '0);
        cyc(4'b1000, '0, SEQ, INCR8, 1'b1, OKAY, '0);
        cyc(4'b1000, '0, SEQ, INCR8, 1'b1, OKAY, '0);
        do_reset();
        chk("t6_master", 32'(HMASTER), 32'h0);
        chk("t6_lock", 32'(HMASTLOCK), 32'h0);
        cyc(4'b0100, '0, IDLE, SINGLE, 1'b1, OKAY, '0);
        chk("t6_mask_clr", 32'(HGRANT), 32'h4);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(N'($urandom), N'($urandom & $urandom & $urandom), 2'($urandom),
                3'($urandom), ($urandom_range(3) != 0),
                ($urandom_range(7) == 0) ? 2'($urandom) : OKAY,
                ($urandom_range(15) == 0) ? 16'($urandom) : 16'h0);
            if ($urandom_range(499) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
